co_serializer: RTL and testbench
================================

Name: co_serializer

Overview:
Upstream feeder for the serial code detector. Accepts parallel code words over a valid/ready handshake and shifts them out one bit per clock on the serial line x that the detector samples. Holds one word in flight plus one pending word, so a producer can sustain back-to-back words with no idle bits. Reports framing (sof), activity (busy) and a count of words sent.

Parameters:
WIDTH, 12, bits per code word (>=2)
GAP, 0, idle bit-times inserted after each word (0..15)
IDLE_BIT, 0, level driven on x when no word is being shifted

Ports:
CLK  in  1  clock, all state on rising edge
RST  in  1  asynchronous reset, active-high
din  in  WIDTH  parallel code word
din_valid  in  1  producer has a word on din
din_ready  out  1  block can accept a word this cycle
msb_first  in  1  bit order for the word being accepted, sampled with it
x  out  1  serial data to detector, registered
x_valid  out  1  x carries a data bit this cycle, registered
sof  out  1  high during the first bit of each word, registered
busy  out  1  SHIFT or GAP state, or pending slot full
words_sent  out  8  count of completed words, wraps 255->0

Behaviour:
- Reset (async, RST=1): state=IDLE; pending slot empty; x=IDLE_BIT; x_valid=0; sof=0; busy=0; words_sent=0; din_ready=0 while RST=1, then 1 from the first cycle after RST is released.
- Accept: a word transfers at a rising edge when din_valid & din_ready. din_ready = !pending_full, driven by a register only; no combinational path from din_valid to din_ready.
- FSM states IDLE, SHIFT, GAP. Bit counter is 0..WIDTH-1. Gap counter is 0..GAP-1.
- IDLE: an accept loads the word, with its msb_first, straight into the shift register. It does not go to the pending slot. The next state is SHIFT. If the accept is at edge k, the first bit is on x during cycle k+1, with x_valid=1 and sof=1.
- SHIFT: one bit per cycle. With msb_first=1 the order is din[WIDTH-1] down to din[0]; otherwise din[0] up to din[WIDTH-1]. The last bit is on x during cycle k+WIDTH. Accepts in this state go to the pending slot.
- At the edge that ends the last bit:
  - words_sent increments.
  - If GAP>0, go to GAP.
  - Else if pending is full, move the pending word into the shift register. The first bit of that word follows in the very next cycle with sof=1, so there is no idle bit.
  - Otherwise go to IDLE.
- GAP: for GAP cycles, x=IDLE_BIT and x_valid=0. At the end of the gap, load the pending word if present (go to SHIFT), else go to IDLE.
- Simultaneous events: the pending slot may be emptied into the shift register and refilled from din at the same edge. This is legal only because din_ready was high in that cycle, i.e. the slot was already empty before that edge. A full slot is never overwritten.
- Outside SHIFT: x=IDLE_BIT, x_valid=0, sof=0.
- msb_first is stored per word. Changing the pin has no effect on words already accepted.
- Reset mid-word discards the shift register and the pending word. It does not count a partial word. x returns to IDLE_BIT immediately, since reset is asynchronous.
- Throughput: with GAP=0, one word per WIDTH cycles sustained. With GAP>0, one word per WIDTH+GAP cycles.

Test Plan:
- WIDTH=12, GAP=0: din=12'b1010_0100_1101, msb_first=1, accepted at edge 0 -> x=1,0,1,0,0,1,0,0,1,1,0,1 in cycles 1..12; x_valid=1 throughout; sof=1 in cycle 1 only; words_sent=1 after edge 12; x=0 and x_valid=0 in cycle 13.
- Same word with msb_first=0 -> x=1,0,1,1,0,0,1,0,0,1,0,1 in cycles 1..12.
- Back-to-back: A=12'hA4D accepted at edge 0 and B=12'h5B2 at edge 3 -> din_ready=0 in cycles 4..12; 24 contiguous x_valid bits; sof in cycles 1 and 13; din_ready=1 again in cycle 13; words_sent=2 after edge 24.
- GAP=2, two queued words -> cycles 13-14 show x=IDLE_BIT, x_valid=0; second sof in cycle 15.
- RST pulsed high in cycle 6 of a word with a word pending -> x=IDLE_BIT and x_valid=0 immediately; words_sent=0; no further bits until a new accept.
- 256 single words -> words_sent wraps to 0 after the 256th; no pending word is lost.

Source files
------------

// File: rtl/co_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : co_serializer
//  Description : Parallel-to-serial feeder for the serial code detector.
//                Accepts code words over valid/ready, holds one word in flight
//                plus one pending word, and shifts each word out one bit per
//                clock on x. Optional idle gap after each word.
//  Revision    : 1.0  initial release
// ============================================================================
module co_serializer #(
    parameter int   WIDTH    = 12,
    parameter int   GAP      = 0,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             msb_first,
    output logic             x,
    output logic             x_valid,
    output logic             sof,
    output logic             busy,
    output logic [7:0]       words_sent
);

    localparam int              c_BW       = $clog2(WIDTH);
    localparam logic [c_BW-1:0] c_BIT_LAST = c_BW'(WIDTH - 1);
    localparam logic [3:0]      c_GAP_LAST = 4'((GAP > 0) ? GAP - 1 : 0);
    localparam logic            c_HAS_GAP  = (GAP > 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [WIDTH-1:0]  r_shift;
    logic              r_msb;
    logic [c_BW-1:0]   r_bitcnt;
    logic [3:0]        r_gapcnt;

    logic [WIDTH-1:0]  r_pend_data;
    logic              r_pend_msb;
    logic              r_pend_full;
    logic              r_ready;

    logic              r_x;
    logic              r_xv;
    logic              r_sof;
    logic [7:0]        r_words;

    logic              w_accept;
    logic              w_last_bit;
    logic              w_gap_end;
    logic              w_boundary;
    logic              w_load;
    logic              w_pend_set;
    logic              w_pend_clr;
    logic              w_pend_full_nxt;
    logic [WIDTH-1:0]  w_ld_data;
    logic              w_ld_msb;

    // Handshake and word-boundary decode. A boundary is any edge at which the
    // shift register is free to take a new word: idle, end of the last bit
    // when there is no gap, or end of the gap. At a boundary the pending word
    // has priority; with the slot empty an incoming word bypasses straight
    // into the shift register so no bit-time is lost.
    always_comb begin
        w_accept        = din_valid & r_ready;
        w_last_bit      = (r_state == S_SHIFT) && (r_bitcnt == c_BIT_LAST);
        w_gap_end       = (r_state == S_GAP) && (r_gapcnt == c_GAP_LAST);
        w_boundary      = (r_state == S_IDLE) || (w_last_bit && !c_HAS_GAP) || w_gap_end;
        w_load          = w_boundary && (r_pend_full || w_accept);
        w_pend_clr      = w_boundary && r_pend_full;
        w_pend_set      = w_accept && !(w_boundary && !r_pend_full);
        w_pend_full_nxt = (r_pend_full && !w_pend_clr) || w_pend_set;
        w_ld_data       = r_pend_full ? r_pend_data : din;
        w_ld_msb        = r_pend_full ? r_pend_msb  : msb_first;
    end

    // Next-state logic for the IDLE / SHIFT / GAP controller.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_load) begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_last_bit) begin
                    if (c_HAS_GAP) begin
                        w_state_nxt = S_GAP;
                    end else if (w_load) begin
                        w_state_nxt = S_SHIFT;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                if (w_gap_end) begin
                    w_state_nxt = w_load ? S_SHIFT : S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Shift register and registered serial outputs. The first bit of a word is
    // taken directly from the loaded data; the shift register then holds the
    // remaining bits aligned so the next bit always sits at the end selected
    // by the word's own stored bit order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_shift  <= '0;
            r_msb    <= 1'b0;
            r_bitcnt <= '0;
            r_x      <= IDLE_BIT;
            r_xv     <= 1'b0;
            r_sof    <= 1'b0;
        end else if (w_load) begin
            r_shift  <= w_ld_msb ? (w_ld_data << 1) : (w_ld_data >> 1);
            r_msb    <= w_ld_msb;
            r_bitcnt <= '0;
            r_x      <= w_ld_msb ? w_ld_data[WIDTH-1] : w_ld_data[0];
            r_xv     <= 1'b1;
            r_sof    <= 1'b1;
        end else if ((r_state == S_SHIFT) && !w_last_bit) begin
            r_shift  <= r_msb ? (r_shift << 1) : (r_shift >> 1);
            r_bitcnt <= r_bitcnt + 1'b1;
            r_x      <= r_msb ? r_shift[WIDTH-1] : r_shift[0];
            r_xv     <= 1'b1;
            r_sof    <= 1'b0;
        end else begin
            r_x      <= IDLE_BIT;
            r_xv     <= 1'b0;
            r_sof    <= 1'b0;
        end
    end

    // Gap timer: restarts at the end of every word, counts while in GAP.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_gapcnt <= '0;
        end else if (w_last_bit) begin
            r_gapcnt <= '0;
        end else if (r_state == S_GAP) begin
            r_gapcnt <= r_gapcnt + 1'b1;
        end
    end

    // Pending slot and registered ready. Ready only reflects slot occupancy,
    // so there is no path from din_valid to din_ready.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_pend_data <= '0;
            r_pend_msb  <= 1'b0;
            r_pend_full <= 1'b0;
            r_ready     <= 1'b0;
        end else begin
            r_pend_full <= w_pend_full_nxt;
            r_ready     <= !w_pend_full_nxt;
            if (w_pend_set) begin
                r_pend_data <= din;
                r_pend_msb  <= msb_first;
            end
        end
    end

    // Completed-word counter, wraps naturally at 8 bits.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_words <= 8'd0;
        end else if (w_last_bit) begin
            r_words <= r_words + 8'd1;
        end
    end

    assign din_ready  = r_ready;
    assign x          = r_x;
    assign x_valid    = r_xv;
    assign sof        = r_sof;
    assign busy       = (r_state != S_IDLE) || r_pend_full;
    assign words_sent = r_words;

endmodule
`default_nettype wire

// File: tb/tb_co_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_co_serializer
//  Description : Self-checking bench for co_serializer. Two instances (no gap
//                and a 2-bit gap) share one stimulus stream; a word-level
//                timeline model predicts every output on every cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_co_serializer;

    localparam int   W  = 12;
    localparam int   G0 = 0;
    localparam int   G1 = 2;
    localparam logic IB = 1'b0;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [W-1:0]  din = '0;
    logic          din_valid = 1'b0;
    logic          msb_first = 1'b0;
    logic [1:0]    din_ready, x, x_valid, sof, busy;
    logic [1:0][7:0] ws;

    int total = 0;
    int bad   = 0;
    int ed    = 0;

    typedef struct packed {
        logic [W-1:0] d;
        logic         m;
        int           a;
        int           s;
    } wrd_t;

    typedef struct packed {
        logic       x;
        logic       xv;
        logic       sof;
        logic       busy;
        logic       rdy;
        logic [7:0] ws;
    } exp_t;

    wrd_t q [2][$];

    co_serializer #(.WIDTH(W), .GAP(G0), .IDLE_BIT(IB)) u_dut0 (
        .CLK(CLK), .RST(RST), .din(din), .din_valid(din_valid),
        .din_ready(din_ready[0]), .msb_first(msb_first), .x(x[0]),
        .x_valid(x_valid[0]), .sof(sof[0]), .busy(busy[0]), .words_sent(ws[0])
    );

    co_serializer #(.WIDTH(W), .GAP(G1), .IDLE_BIT(IB)) u_dut1 (
        .CLK(CLK), .RST(RST), .din(din), .din_valid(din_valid),
        .din_ready(din_ready[1]), .msb_first(msb_first), .x(x[1]),
        .x_valid(x_valid[1]), .sof(sof[1]), .busy(busy[1]), .words_sent(ws[1])
    );

    always #5 CLK = ~CLK;

    function automatic int gapv(input int i);
        return (i == 0) ? G0 : G1;
    endfunction

    // Expected outputs during cycle c (the cycle ending at edge c). Each word
    // occupies bits [s, s+W-1], then its gap; it waits in the slot between
    // its accept edge and the edge before its first bit.
    function automatic exp_t m_out(input int i, input int c);
        exp_t e;
        int   n;
        int   g;
        int   j;
        wrd_t w;
        g      = gapv(i);
        n      = 0;
        e.x    = IB;
        e.xv   = 1'b0;
        e.sof  = 1'b0;
        e.busy = 1'b0;
        e.rdy  = (c >= 1);
        for (int k = 0; k < q[i].size(); k++) begin
            w = q[i][k];
            if (c >= w.s && c <= w.s + W - 1) begin
                j     = c - w.s;
                e.xv  = 1'b1;
                e.sof = (j == 0);
                e.x   = w.m ? w.d[W-1-j] : w.d[j];
            end
            if (c >= w.s && c <= w.s + W + g - 1) e.busy = 1'b1;
            if (c >= w.a + 1 && c <= w.s - 1) begin
                e.busy = 1'b1;
                e.rdy  = 1'b0;
            end
            if (w.s + W <= c) n++;
        end
        e.ws = 8'(n);
        return e;
    endfunction

    task automatic chk(input string nm, input int i, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d t=%0t got=%0h want=%0h", nm, i, $time, act, exp);
        end
    endtask

    // Model update at each active edge: acceptance and scheduling of words.
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            q[0].delete();
            q[1].delete();
            ed = 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                exp_t e;
                e = m_out(i, ed);
                if (din_valid && e.rdy) begin
                    wrd_t w;
                    int   s;
                    s = ed + 1;
                    if (q[i].size() > 0 && q[i][q[i].size()-1].s + W + gapv(i) > s)
                        s = q[i][q[i].size()-1].s + W + gapv(i);
                    w.d = din;
                    w.m = msb_first;
                    w.a = ed;
                    w.s = s;
                    q[i].push_back(w);
                end
            end
            ed = ed + 1;
        end
    end

    // Every-cycle comparison against the model, on the inactive edge.
    always @(negedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            exp_t e;
            if (RST) begin
                e.x = IB; e.xv = 1'b0; e.sof = 1'b0; e.busy = 1'b0; e.rdy = 1'b0; e.ws = 8'd0;
            end else begin
                e = m_out(i, ed);
            end
            chk("x",          i, {7'd0, x[i]},         {7'd0, e.x});
            chk("x_valid",    i, {7'd0, x_valid[i]},   {7'd0, e.xv});
            chk("sof",        i, {7'd0, sof[i]},       {7'd0, e.sof});
            chk("busy",       i, {7'd0, busy[i]},      {7'd0, e.busy});
            chk("din_ready",  i, {7'd0, din_ready[i]}, {7'd0, e.rdy});
            chk("words_sent", i, ws[i],                e.ws);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #2;
        end
    endtask

    // Present a word for exactly one cycle, then flip msb_first so a stored
    // bit order is distinguishable from the live pin.
    task automatic offer(input logic [W-1:0] d, input logic m);
        din       = d;
        msb_first = m;
        din_valid = 1'b1;
        @(posedge CLK);
        #2;
        din_valid = 1'b0;
        din       = '0;
        msb_first = ~m;
    endtask

    task automatic capture_word(input logic [W-1:0] d, input logic m, input logic [W-1:0] want);
        logic [W-1:0] sx, sf, sv;
        offer(d, m);
        for (int j = 0; j < W; j++) begin
            sx[W-1-j] = x[0];
            sf[W-1-j] = sof[0];
            sv[W-1-j] = x_valid[0];
            idle(1);
        end
        chk("lit_stream",  0, sx[7:0],        want[7:0]);
        chk("lit_stream_hi", 0, {4'd0, sx[W-1:8]}, {4'd0, want[W-1:8]});
        chk("lit_sof",     0, {4'd0, sf[W-1:8]} | sf[7:0], 8'h08);
        chk("lit_xv_all",  0, {7'd0, &sv},    8'd1);
        chk("lit_after_xv", 0, {7'd0, x_valid[0]}, 8'd0);
        chk("lit_after_x",  0, {7'd0, x[0]},       {7'd0, IB});
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int nrdy0, nrdy1, nxv;
        idle(3);
        RST = 1'b0;
        idle(2);

        // Single word, msb first, then lsb first.
        capture_word(12'hA4D, 1'b1, 12'b1010_0100_1101);
        chk("lit_ws_1", 0, ws[0], 8'd1);
        idle(4);
        capture_word(12'hA4D, 1'b0, 12'b1011_0010_0101);
        chk("lit_ws_2", 0, ws[0], 8'd2);
        idle(6);

        // Back-to-back A then B three cycles later; C offered while full.
        offer(12'hA4D, 1'b1);
        idle(2);
        offer(12'h5B2, 1'b1);
        nrdy0 = din_ready[0];
        nrdy1 = din_ready[1];
        offer(12'hFFF, 1'b0);
        for (int k = 5; k <= 12; k++) begin
            nrdy0 += din_ready[0];
            nrdy1 += din_ready[1];
            idle(1);
        end
        chk("lit_b2b_rdy_low", 0, 8'(nrdy0), 8'd0);
        chk("lit_gap_rdy_low", 1, 8'(nrdy1), 8'd0);
        chk("lit_b2b_rdy13",   0, {7'd0, din_ready[0]}, 8'd1);
        chk("lit_b2b_sof13",   0, {7'd0, sof[0]},       8'd1);
        chk("lit_gap_xv13",    1, {7'd0, x_valid[1]},   8'd0);
        idle(1);
        chk("lit_gap_xv14",    1, {7'd0, x_valid[1]},   8'd0);
        chk("lit_gap_x14",     1, {7'd0, x[1]},         {7'd0, IB});
        idle(1);
        chk("lit_gap_sof15",   1, {7'd0, sof[1]},       8'd1);
        idle(10);
        chk("lit_b2b_ws",      0, ws[0], 8'd4);
        chk("lit_gap_ws25",    1, ws[1], 8'd3);
        idle(2);
        chk("lit_gap_ws27",    1, ws[1], 8'd4);
        idle(20);

        // Reset in cycle 6 of a word with a second word pending.
        offer(12'h3C7, 1'b1);
        offer(12'h81E, 1'b0);
        idle(4);
        RST = 1'b1;
        #1;
        chk("lit_rst_x",    0, {7'd0, x[0]},       {7'd0, IB});
        chk("lit_rst_xv0",  0, {7'd0, x_valid[0]}, 8'd0);
        chk("lit_rst_xv1",  1, {7'd0, x_valid[1]}, 8'd0);
        chk("lit_rst_ws",   0, ws[0],              8'd0);
        chk("lit_rst_busy", 0, {7'd0, busy[0]},    8'd0);
        @(posedge CLK);
        #2;
        RST = 1'b0;
        nxv = 0;
        for (int k = 0; k < 20; k++) begin
            idle(1);
            nxv += x_valid[0] + x_valid[1];
        end
        chk("lit_rst_quiet", 0, 8'(nxv), 8'd0);
        chk("lit_rst_ws2",   1, ws[1],   8'd0);

        // 256 words: counter wraps to 0; the last two are queued back-to-back.
        for (int i = 0; i < 254; i++) begin
            offer(W'(i * 37) ^ 12'h5A3, 1'(i));
            idle(17);
        end
        chk("lit_ws_254", 0, ws[0], 8'd254);
        offer(12'hC35, 1'b1);
        offer(12'h0F1, 1'b0);
        idle(40);
        chk("lit_wrap0", 0, ws[0], 8'd0);
        chk("lit_wrap1", 1, ws[1], 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
